// File: rtl/bsg_cgol_ctrl_seq.sv
// Game-of-Life array controller: load handshake, counted/free-run/single-step stepping, settle gaps, abort.
// Define BSG_CGOL_CTRL_PERF_EN to add the busy_cycles_o performance counter.
module bsg_cgol_ctrl_seq #(
  parameter int max_game_length_p = 1024,
  parameter int settle_cycles_p   = 0,
  localparam int game_len_width_lp =
    ((max_game_length_p + 1) <= 1) ? 1 : $clog2(max_game_length_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  input  logic [game_len_width_lp-1:0] frames_i,
  input  logic [1:0]                   mode_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic                         abort_i,
  input  logic                         yumi_i,
  output logic                         v_o,
  output logic [game_len_width_lp-1:0] frames_done_o,
  output logic                         update_o,
  output logic                         en_o
`ifdef BSG_CGOL_CTRL_PERF_EN
  ,output logic [31:0]                 busy_cycles_o
`endif
);

  localparam int settle_width_lp =
    (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam logic [settle_width_lp-1:0] settle_init_lp =
    (settle_cycles_p > 0) ? settle_width_lp'(settle_cycles_p - 1) : '0;
  localparam logic [game_len_width_lp-1:0] max_frames_lp =
    game_len_width_lp'(max_game_length_p);

  typedef enum logic [1:0] {eIDLE, eRUN, eSETTLE, eDONE} state_e;

  state_e                         state_q, state_d;
  logic [game_len_width_lp-1:0]   cnt_q, cnt_d;
  logic [game_len_width_lp-1:0]   frames_q, frames_d;
  logic                           free_q, free_d;
  logic [settle_width_lp-1:0]     settle_q, settle_d;

  logic                           mode_free, mode_step;
  logic [game_len_width_lp-1:0]   frames_clamped;
  logic [game_len_width_lp-1:0]   cnt_inc;
  logic                           accept;

  assign mode_free      = (mode_i == 2'd1);
  assign mode_step      = (mode_i == 2'd2);
  assign frames_clamped = (frames_i > max_frames_lp) ? max_frames_lp : frames_i;
  // Saturating increment keeps free-run games from wrapping the reported count.
  assign cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign accept         = update_o;
  assign frames_done_o  = cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    free_d   = free_q;
    settle_d = settle_q;
    ready_o  = 1'b0;
    v_o      = 1'b0;
    update_o = 1'b0;
    en_o     = 1'b0;

    if (en_i) begin
      case (state_q)
        eIDLE: begin
          ready_o = 1'b1;
          if (v_i) begin
            update_o = 1'b1;
            cnt_d    = '0;
            free_d   = mode_free;
            frames_d = mode_step ? game_len_width_lp'(1) : frames_clamped;
            if (!mode_free && !mode_step && (frames_clamped == '0))
              state_d = eDONE;
            else
              state_d = eRUN;
          end
        end

        eRUN: begin
          if (abort_i) begin
            state_d = eDONE;
          end else begin
            en_o  = 1'b1;
            cnt_d = cnt_inc;
            if (settle_cycles_p > 0) begin
              state_d  = eSETTLE;
              settle_d = settle_init_lp;
            end else if (!free_q && (cnt_inc == frames_q)) begin
              state_d = eDONE;
            end else begin
              state_d = eRUN;
            end
          end
        end

        eSETTLE: begin
          if (abort_i) begin
            state_d = eDONE;
          end else if (settle_q == '0) begin
            state_d = (!free_q && (cnt_q == frames_q)) ? eDONE : eRUN;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end

        eDONE: begin
          v_o = 1'b1;
          if (yumi_i)
            state_d = eIDLE;
        end

        default: state_d = eIDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIDLE;
      cnt_q    <= '0;
      frames_q <= '0;
      free_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      free_q   <= free_d;
      settle_q <= settle_d;
    end
  end

`ifdef BSG_CGOL_CTRL_PERF_EN
  logic [31:0] busy_q, busy_d;

  // Counts every enabled cycle in eRUN/eSETTLE, including an aborting cycle.
  always_comb begin
    busy_d = busy_q;
    if (accept)
      busy_d = '0;
    else if (en_i && ((state_q == eRUN) || (state_q == eSETTLE)) && (busy_q != '1))
      busy_d = busy_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_cycles_o = busy_q;
`endif

endmodule

// File: tb/tb_bsg_cgol_ctrl_seq.sv
// Scoreboard bench: three controllers (settle gap 0, 1, 2) driven by directed and random games.
module tb_bsg_cgol_ctrl_seq;

  localparam int MAX = 20;
  localparam int W   = $clog2(MAX + 1);
  localparam int SAT = (1 << W) - 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit done_flag [3];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fd;
    int pulses;
    int lat;
    int busy;
  } exp_t;

  function automatic void check(string name, longint act, longint exp, int s);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [settle=%0d]: got %0d, expected %0d", name, s, act, exp);
    end
  endfunction

  // Game outcome from the request alone: generations run, cycles from accept to v_o, busy cycles.
  function automatic exp_t model(int s, int frames, int mode, int abort_k);
    exp_t e;
    int   eff;
    bit   free;
    free = (mode == 1);
    eff  = (mode == 2) ? 1 : ((frames > MAX) ? MAX : frames);
    if (abort_k >= 0 && (free || abort_k < eff)) begin
      e.pulses = abort_k;
      e.lat    = abort_k * (s + 1) + 2;
      e.busy   = abort_k * (s + 1) + 1;
    end else begin
      e.pulses = eff;
      e.lat    = (eff == 0) ? 1 : eff * (s + 1) + 1;
      e.busy   = eff * (s + 1);
    end
    e.fd = (e.pulses > SAT) ? SAT : e.pulses;
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int S = gi;

    logic         reset_n, en, v_i, ready, abort, yumi, v_o, update, en_o;
    logic [W-1:0] frames, frames_done;
    logic [1:0]   mode;
`ifdef BSG_CGOL_CTRL_PERF_EN
    logic [31:0]  busy;
`endif
    exp_t exp_q[$];

    bsg_cgol_ctrl_seq #(.max_game_length_p(MAX), .settle_cycles_p(S)) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .en_i          (en),
      .frames_i      (frames),
      .mode_i        (mode),
      .v_i           (v_i),
      .ready_o       (ready),
      .abort_i       (abort),
      .yumi_i        (yumi),
      .v_o           (v_o),
      .frames_done_o (frames_done),
      .update_o      (update),
      .en_o          (en_o)
`ifdef BSG_CGOL_CTRL_PERF_EN
      ,.busy_cycles_o (busy)
`endif
    );

    // Monitor: follows each game from its update_o pulse to its first v_o cycle.
    int lat, pulses, last;
    bit active;

    always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
        active = 1'b0;
      end else if (!en) begin
        check("frozen_outputs", {ready, v_o, update, en_o}, 0, S);
      end else begin
        check("update_en_overlap", update & en_o, 0, S);
        if (update) begin
          active = 1'b1;
          lat    = 0;
          pulses = 0;
          last   = 0;
        end else if (active) begin
          lat++;
          if (en_o) begin
            check("pulse_spacing", lat - last, (pulses == 0) ? 1 : S + 1, S);
            pulses++;
            last = lat;
          end
          if (v_o) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_v_o", 1, 0, S);
            end else begin
              e = exp_q.pop_front();
              check("frames_done", frames_done, e.fd, S);
              check("en_pulses", pulses, e.pulses, S);
              check("latency", lat, e.lat, S);
`ifdef BSG_CGOL_CTRL_PERF_EN
              check("busy_cycles", busy, e.busy, S);
`endif
            end
          end
        end
      end
    end

    task automatic run_game(int f, int m, int abort_k, int frz_at, int frz_len, int ydly);
      exp_t e;
      int   off;
      int   guard;
      bit   frozen;
      guard = 0;
      while (!ready && guard < 200) begin
        abort = 1'($urandom);
        @(posedge clk); #1;
        guard++;
      end
      abort = 1'b0;
      if (!ready) begin
        check("ready_wait", 0, 1, S);
        return;
      end
      frames = f[W-1:0];
      mode   = m[1:0];
      v_i    = 1'b1;
      e = model(S, f, m, abort_k);
      exp_q.push_back(e);
      #1;
      check("update_at_accept", update, 1, S);
      @(posedge clk); #1;
      v_i    = 1'b0;
      frames = W'($urandom);
      mode   = 2'($urandom);
      off    = 1;
      frozen = 1'b0;
      guard  = 0;
      while (guard < 4000) begin
        if (!frozen && off == frz_at) begin
          frozen = 1'b1;
          en = 1'b0;
          repeat (frz_len) begin @(posedge clk); #1; end
          en = 1'b1;
        end
        abort = (abort_k >= 0) && (off == 1 + abort_k * (S + 1));
        yumi  = (off == 1) && (e.lat > 1);
        #1;
        if (v_o) break;
        @(posedge clk); #1;
        off++;
        guard++;
      end
      abort = 1'b0;
      yumi  = 1'b0;
      if (!v_o) begin
        check("v_o_timeout", 0, 1, S);
        return;
      end
      repeat (ydly) begin
        abort = 1'($urandom);
        @(posedge clk); #1;
      end
      abort = 1'b0;
      yumi  = 1'b1;
      @(posedge clk); #1;
      yumi  = 1'b0;
      check("ready_after_yumi", ready, 1, S);
    endtask

    initial begin
      int m, f, k, fz, fl;
      reset_n = 1'b0; en = 1'b1; v_i = 1'b0; abort = 1'b0; yumi = 1'b0;
      frames  = '0;   mode = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset_ready", ready, 1, S);
      check("reset_v_o", v_o, 0, S);
      check("reset_update", update, 0, S);
      check("reset_en_o", en_o, 0, S);
      check("reset_frames_done", frames_done, 0, S);

      run_game(5, 0, -1, -1, 0, 0);
      run_game(3, 0, -1, -1, 0, 2);
      run_game(9, 1, 6, -1, 0, 1);
      run_game(0, 0, -1, -1, 0, 0);
      run_game(31, 0, -1, -1, 0, 1);
      run_game(9, 2, -1, -1, 0, 0);
      run_game(4, 3, -1, -1, 0, 0);
      run_game(4, 0, -1, 3, 4, 0);
      run_game(4, 1, 40, -1, 0, 0);
      run_game(7, 0, 2, -1, 0, 1);
      run_game(0, 0, 0, -1, 0, 0);

      repeat (25) begin
        m  = int'($urandom_range(0, 3));
        f  = int'($urandom_range(0, MAX + 8));
        if (m == 1)                    k = int'($urandom_range(0, 11));
        else if ($urandom_range(0, 2) == 0) k = int'($urandom_range(0, f));
        else                           k = -1;
        fz = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
        fl = int'($urandom_range(1, 5));
        run_game(f, m, k, fz, fl, int'($urandom_range(0, 2)));
      end

      // Asynchronous reset in the middle of a running game.
      while (!ready) begin @(posedge clk); #1; end
      frames = W'(10); mode = 2'd0; v_i = 1'b1;
      @(posedge clk); #1;
      v_i = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_ready", ready, 1, S);
      check("async_reset_en_o", en_o, 0, S);
      check("async_reset_v_o", v_o, 0, S);
      check("async_reset_frames_done", frames_done, 0, S);
      @(posedge clk); #1;
      reset_n = 1'b1;
      run_game(2, 0, -1, -1, 0, 0);

      repeat (5) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0, S);
      done_flag[gi] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done_flag[0] && done_flag[1] && done_flag[2]) && cyc < 80000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 80000) begin
      n_checks++;
      n_fail++;
      $display("FAIL global_timeout: got %0d cycles, expected completion before 80000", cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
